// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, read-return
// routing, CPU address classes and the default I/O register addresses.
package dmem_arb_pkg;

   localparam logic [31:0] IO_SW_ADDR_DEF  = 32'd4096;
   localparam logic [31:0] IO_LED_ADDR_DEF = 32'd4097;

   // Starvation counter width; covers limits up to 255.
   localparam int CNT_W = 8;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_FORCE = 1'b1
   } arb_state_t;

   // Owner of the read issued this cycle; steers the data returned next cycle.
   typedef enum logic [2:0] {
      RD_NONE    = 3'd0,
      RD_CPU_RAM = 3'd1,
      RD_CPU_SW  = 3'd2,
      RD_CPU_LED = 3'd3,
      RD_DMA     = 3'd4
   } rd_src_t;

   typedef enum logic [1:0] {
      CLS_RAM = 2'd0,
      CLS_SW  = 2'd1,
      CLS_LED = 2'd2
   } addr_cls_t;

   // Full 32-bit compare: only the exact I/O addresses leave the RAM space.
   function automatic addr_cls_t classify(input logic [31:0] addr,
                                          input logic [31:0] sw_a,
                                          input logic [31:0] led_a);
      addr_cls_t cls;
      cls = CLS_RAM;
      if (addr == sw_a) begin
         cls = CLS_SW;
      end else if (addr == led_a) begin
         cls = CLS_LED;
      end
      return cls;
   endfunction

endpackage

// File: rtl/dmem_arbiter_sync2.sv
// Two-flop synchroniser for a bus of quasi-static asynchronous inputs
// (switches); each bit is synchronised independently.
module sync2 #(
   parameter int W = 16
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Metastability stage followed by the stable output stage.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data RAM between the CPU
// MEM stage and the read-only audio DMA, decodes the switch/LED registers,
// and forces a one-cycle DMA grant (stalling the CPU) after a bounded wait.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ARB   | normal arbitration; CPU RAM access wins, DMA takes idle slots
// ST_FORCE | one cycle: CPU stalled, its side effects dropped, DMA owns RAM
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int          ADDR_W       = 12,
   parameter logic [31:0] IO_SW_ADDR   = IO_SW_ADDR_DEF,
   parameter logic [31:0] IO_LED_ADDR  = IO_LED_ADDR_DEF,
   parameter int          STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_en,
   input  logic              cpu_wren,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_data,
   output logic [31:0]       cpu_q,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              dma_gnt,
   output logic              dma_valid,
   output logic [31:0]       dma_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wEn,
   output logic [31:0]       ram_dataIn,
   input  logic [31:0]       ram_dataOut,
   input  logic [15:0]       sw_in,
   output logic [15:0]       led
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   rd_src_t          r_rd_src;
   rd_src_t          w_rd_src_nxt;
   logic             r_dma_valid;
   logic [15:0]      r_led;
   logic [15:0]      w_sw_sync;
   addr_cls_t        w_cls;
   logic             w_cpu_ram;
   logic             w_led_wr;

   assign w_cls     = classify(cpu_addr, IO_SW_ADDR, IO_LED_ADDR);
   assign w_cpu_ram = cpu_en && (w_cls == CLS_RAM);

   sync2 #(.W(16)) u_sw_sync (
      .i_clock (clock),
      .i_reset (reset),
      .i_d     (sw_in),
      .o_q     (w_sw_sync)
   );

   // FSM state register and starvation counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_ARB;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: count denied DMA cycles, enter FORCE when the limit is hit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         ST_ARB: begin
            if (dma_req && !dma_gnt) begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_cnt_nxt == LIMIT) begin
                  w_state_nxt = ST_FORCE;
               end
            end
         end
         ST_FORCE: begin
            w_state_nxt = ST_ARB;
         end
         default: begin
            w_state_nxt = ST_ARB;
         end
      endcase
   end

   // Port ownership and handshake outputs; reset silences everything at once.
   always_comb begin
      cpu_stall  = 1'b0;
      dma_gnt    = 1'b0;
      ram_addr   = dma_addr;
      ram_wEn    = 1'b0;
      ram_dataIn = cpu_data;
      if (!reset) begin
         case (r_state)
            ST_ARB: begin
               if (w_cpu_ram) begin
                  ram_addr = cpu_addr[ADDR_W-1:0];
                  ram_wEn  = cpu_wren;
               end else if (dma_req) begin
                  dma_gnt = 1'b1;
               end
            end
            ST_FORCE: begin
               // A dropped request still burns the forced cycle, just ungranted.
               cpu_stall = 1'b1;
               dma_gnt   = dma_req;
            end
            default: begin
               cpu_stall = 1'b0;
            end
         endcase
      end
   end

   // Pick who gets data back next cycle. A CPU I/O load may coincide with a
   // DMA grant, so DMA validity is carried separately in r_dma_valid.
   always_comb begin
      w_rd_src_nxt = RD_NONE;
      if (r_state == ST_ARB && cpu_en && !cpu_wren) begin
         case (w_cls)
            CLS_RAM: w_rd_src_nxt = RD_CPU_RAM;
            CLS_SW:  w_rd_src_nxt = RD_CPU_SW;
            CLS_LED: w_rd_src_nxt = RD_CPU_LED;
            default: w_rd_src_nxt = RD_NONE;
         endcase
      end else if (dma_gnt) begin
         w_rd_src_nxt = RD_DMA;
      end
   end

   // LED stores only take effect in ARB; stores to the switch address are dropped.
   assign w_led_wr = (r_state == ST_ARB) && cpu_en && cpu_wren && (w_cls == CLS_LED);

   // Return-path routing and LED register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_src    <= RD_NONE;
         r_dma_valid <= 1'b0;
         r_led       <= '0;
      end else begin
         r_rd_src    <= w_rd_src_nxt;
         r_dma_valid <= dma_gnt;
         if (w_led_wr) begin
            r_led <= cpu_data[15:0];
         end
      end
   end

   // CPU load data mux, driven from last cycle's routing decision.
   always_comb begin
      cpu_q = '0;
      case (r_rd_src)
         RD_CPU_RAM: cpu_q = ram_dataOut;
         RD_CPU_SW:  cpu_q = {16'h0000, w_sw_sync};
         RD_CPU_LED: cpu_q = {16'h0000, r_led};
         default:    cpu_q = '0;
      endcase
   end

   assign dma_valid = r_dma_valid;
   assign dma_q     = ram_dataOut;
   assign led       = r_led;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: constant vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_dmem_arbiter;

   localparam int LIMIT = 8;

   logic        clock;
   logic        reset;
   logic        cpu_en;
   logic        cpu_wren;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_data;
   logic [31:0] cpu_q;
   logic        cpu_stall;
   logic        dma_req;
   logic [11:0] dma_addr;
   logic        dma_gnt;
   logic        dma_valid;
   logic [31:0] dma_q;
   logic [11:0] ram_addr;
   logic        ram_wEn;
   logic [31:0] ram_dataIn;
   logic [31:0] ram_dataOut;
   logic [15:0] sw_in;
   logic [15:0] led;

   dmem_arbiter #(
      .ADDR_W       (12),
      .IO_SW_ADDR   (32'd4096),
      .IO_LED_ADDR  (32'd4097),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cpu_en      (cpu_en),
      .cpu_wren    (cpu_wren),
      .cpu_addr    (cpu_addr),
      .cpu_data    (cpu_data),
      .cpu_q       (cpu_q),
      .cpu_stall   (cpu_stall),
      .dma_req     (dma_req),
      .dma_addr    (dma_addr),
      .dma_gnt     (dma_gnt),
      .dma_valid   (dma_valid),
      .dma_q       (dma_q),
      .ram_addr    (ram_addr),
      .ram_wEn     (ram_wEn),
      .ram_dataIn  (ram_dataIn),
      .ram_dataOut (ram_dataOut),
      .sw_in       (sw_in),
      .led         (led)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] preload(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
   endfunction

   // External single-port RAM with a registered read; port signals are
   // captured mid-cycle so the posedge update never races the DUT.
   logic [31:0] ram_mem [4096];
   initial begin
      logic [11:0] a;
      logic        w;
      logic [31:0] d;
      for (int i = 0; i < 4096; i++) ram_mem[i] = preload(i);
      ram_mem[16] = 32'hDEADBEEF;
      forever begin
         @(negedge clock);
         a = ram_addr;
         w = ram_wEn;
         d = ram_dataIn;
         @(posedge clock);
         ram_dataOut <= ram_mem[a];
         if (w) ram_mem[a] = d;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_mem [4096];
   bit          m_known = 0;
   bit          m_force = 0;
   int          m_wait  = 0;
   logic [15:0] m_led   = '0;
   logic [15:0] m_sw1   = '0;
   logic [15:0] m_sw2   = '0;
   logic [31:0] m_q     = '0;
   bit          m_dv    = 0;
   logic [31:0] m_dq    = '0;
   bit          e_stall, e_gnt, e_wen;
   int          e_own;
   bit          last_gnt = 0;

   function automatic int cls_of(input logic [31:0] a);
      if (a == 32'd4096) return 1;
      if (a == 32'd4097) return 2;
      return 0;
   endfunction

   // Mid-cycle: compare every output against the model.
   task automatic sample();
      int cls;
      @(negedge clock);
      cls     = cls_of(cpu_addr);
      e_stall = 0; e_gnt = 0; e_wen = 0; e_own = 0;
      if (!reset) begin
         if (m_force) begin
            e_stall = 1;
            e_gnt   = dma_req;
            e_own   = dma_req ? 2 : 0;
         end else if (cpu_en && cls == 0) begin
            e_own = 1;
            e_wen = cpu_wren;
         end else if (dma_req) begin
            e_gnt = 1;
            e_own = 2;
         end
      end
      chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      chk("dma_gnt", 32'(dma_gnt), 32'(e_gnt));
      chk("ram_wEn", 32'(ram_wEn), 32'(e_wen));
      if (e_own == 1) chk("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr[11:0]));
      if (e_own == 2) chk("ram_addr_dma", 32'(ram_addr), 32'(dma_addr));
      if (e_wen) chk("ram_dataIn", ram_dataIn, cpu_data);
      if (m_known) begin
         chk("cpu_q", cpu_q, m_q);
         chk("dma_valid", 32'(dma_valid), 32'(m_dv));
         chk("led", 32'(led), 32'(m_led));
         if (m_dv) chk("dma_q", dma_q, m_dq);
      end
   endtask

   // Clock edge: advance the model with this cycle's inputs.
   task automatic advance();
      int          cls;
      logic [31:0] nq;
      @(posedge clock);
      cls = cls_of(cpu_addr);
      if (reset) begin
         m_known = 1; m_force = 0; m_wait = 0;
         m_led = '0; m_sw1 = '0; m_sw2 = '0;
         m_q = '0; m_dv = 0;
      end else begin
         nq = '0;
         if (!m_force && cpu_en && !cpu_wren) begin
            if (cls == 0) nq = m_mem[cpu_addr[11:0]];
            else if (cls == 1) nq = {16'h0000, m_sw1};
            else nq = {16'h0000, m_led};
         end
         m_dv = e_gnt;
         if (e_gnt) m_dq = m_mem[dma_addr];
         if (e_wen) m_mem[cpu_addr[11:0]] = cpu_data;
         if (!m_force && cpu_en && cpu_wren && cls == 2) m_led = cpu_data[15:0];
         m_sw2 = m_sw1;
         m_sw1 = sw_in;
         if (m_force) begin
            m_force = 0;
            m_wait  = 0;
         end else if (dma_req && !e_gnt) begin
            m_wait++;
            if (m_wait == LIMIT) m_force = 1;
         end else begin
            m_wait = 0;
         end
         m_q = nq;
      end
      last_gnt = e_gnt;
      #1;
   endtask

   task automatic drive(input bit en, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit dreq, input logic [11:0] da);
      cpu_en = en; cpu_wren = wr; cpu_addr = a; cpu_data = d;
      dma_req = dreq; dma_addr = da;
   endtask

   task automatic idle();
      drive(0, 0, 32'h0, 32'h0, 0, 12'h000);
      sample();
      advance();
   endtask

   typedef struct {
      bit          rst;
      bit          en;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      bit          dreq;
      logic [11:0] daddr;
      bit          e_stall;
      bit          e_gnt;
      bit          e_wen;
      bit          ca;
      logic [11:0] e_addr;
   } vec_t;

   vec_t vt [8];

   initial begin
      vt[0] = '{0, 0, 0, 32'h0,        32'h0,        0, 12'h000, 0, 0, 0, 0, 12'h000};
      vt[1] = '{0, 1, 0, 32'h5,        32'h0,        0, 12'h000, 0, 0, 0, 1, 12'h005};
      vt[2] = '{0, 1, 1, 32'h6,        32'h11112222, 1, 12'h030, 0, 0, 1, 1, 12'h006};
      vt[3] = '{0, 1, 1, 32'd4097,     32'h00003C3C, 1, 12'h030, 0, 1, 0, 1, 12'h030};
      vt[4] = '{0, 1, 0, 32'd4096,     32'h0,        1, 12'h031, 0, 1, 0, 1, 12'h031};
      vt[5] = '{0, 1, 0, 32'h00010007, 32'h0,        0, 12'h000, 0, 0, 0, 1, 12'h007};
      vt[6] = '{0, 1, 1, 32'd4096,     32'h0000FFFF, 0, 12'h000, 0, 0, 0, 0, 12'h000};
      vt[7] = '{1, 1, 1, 32'h8,        32'h00000077, 1, 12'h032, 0, 0, 0, 0, 12'h000};

      for (int i = 0; i < 4096; i++) m_mem[i] = preload(i);
      m_mem[16] = 32'hDEADBEEF;

      reset = 1'b1;
      sw_in = 16'h0000;
      drive(0, 0, 32'h0, 32'h0, 0, 12'h000);
      sample(); advance();
      sample(); advance();
      reset = 1'b0;
      idle();
      chk("reset_led", 32'(led), 32'h0);
      chk("reset_dma_valid", 32'(dma_valid), 32'h0);

      // DMA alone: granted immediately, data the next cycle.
      drive(0, 0, 32'h0, 32'h0, 1, 12'h010);
      sample();
      chk("dma_only_gnt", 32'(dma_gnt), 32'h1);
      advance();
      drive(0, 0, 32'h0, 32'h0, 0, 12'h000);
      sample();
      chk("dma_only_valid", 32'(dma_valid), 32'h1);
      chk("dma_only_q", dma_q, 32'hDEADBEEF);
      advance();

      // Constant vector table.
      for (int v = 0; v < 8; v++) begin
         reset = vt[v].rst;
         drive(vt[v].en, vt[v].wr, vt[v].addr, vt[v].data, vt[v].dreq, vt[v].daddr);
         sample();
         chk($sformatf("vec%0d_stall", v), 32'(cpu_stall), 32'(vt[v].e_stall));
         chk($sformatf("vec%0d_gnt", v), 32'(dma_gnt), 32'(vt[v].e_gnt));
         chk($sformatf("vec%0d_wen", v), 32'(ram_wEn), 32'(vt[v].e_wen));
         if (vt[v].ca) chk($sformatf("vec%0d_addr", v), 32'(ram_addr), 32'(vt[v].e_addr));
         advance();
      end
      reset = 1'b0;
      idle();

      // Contention: CPU reads every cycle, DMA forced through on cycle 8.
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 32'h40 + 32'(k), 32'h0, 1, 12'h050);
         sample();
         chk($sformatf("starve_gnt_c%0d", k), 32'(dma_gnt), 32'(k == 8));
         chk($sformatf("starve_stall_c%0d", k), 32'(cpu_stall), 32'(k == 8));
         advance();
      end
      idle();

      // CPU store held across the forced cycle commits only afterwards.
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 32'h60, 32'h0, 1, 12'h051);
         sample(); advance();
      end
      drive(1, 1, 32'h20, 32'h5, 1, 12'h051);
      sample();
      chk("force_store_wen", 32'(ram_wEn), 32'h0);
      chk("force_store_stall", 32'(cpu_stall), 32'h1);
      advance();
      sample();
      chk("post_force_wen", 32'(ram_wEn), 32'h1);
      chk("post_force_addr", 32'(ram_addr), 32'h020);
      advance();
      drive(1, 0, 32'h20, 32'h0, 0, 12'h000);
      sample(); advance();
      drive(0, 0, 32'h0, 32'h0, 0, 12'h000);
      sample();
      chk("store_readback", cpu_q, 32'h5);
      advance();

      // I/O: LED store with a concurrent DMA grant, then a switch load.
      drive(1, 1, 32'd4097, 32'h0000A5A5, 1, 12'h011);
      sample();
      chk("led_store_dma_gnt", 32'(dma_gnt), 32'h1);
      advance();
      drive(0, 0, 32'h0, 32'h0, 0, 12'h000);
      sw_in = 16'h1234;
      sample();
      chk("led_value", 32'(led), 32'h0000A5A5);
      advance();
      sample(); advance();
      drive(1, 0, 32'd4096, 32'h0, 1, 12'h012);
      sample();
      chk("sw_load_dma_gnt", 32'(dma_gnt), 32'h1);
      advance();
      drive(0, 0, 32'h0, 32'h0, 0, 12'h000);
      sample();
      chk("sw_load_q", cpu_q, 32'h00001234);
      chk("sw_load_dma_valid", 32'(dma_valid), 32'h1);
      advance();

      // Reset during the forced cycle aborts it; counting restarts from 0.
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 32'h70, 32'h0, 1, 12'h052);
         sample(); advance();
      end
      reset = 1'b1;
      sample();
      chk("rst_force_gnt", 32'(dma_gnt), 32'h0);
      chk("rst_force_stall", 32'(cpu_stall), 32'h0);
      advance();
      reset = 1'b0;
      for (int k = 0; k < 9; k++) begin
         sample();
         if (k == 0) begin
            chk("rst_force_led", 32'(led), 32'h0);
            chk("rst_force_dma_valid", 32'(dma_valid), 32'h0);
         end
         chk($sformatf("rst_restart_gnt_c%0d", k), 32'(dma_gnt), 32'(k == 8));
         advance();
      end
      idle();

      // Randomized run against the model.
      for (int c = 0; c < 3000; c++) begin
         int r;
         reset    = ($urandom_range(0, 199) == 0);
         cpu_en   = ($urandom_range(0, 9) < 6);
         cpu_wren = ($urandom_range(0, 9) < 3);
         r = $urandom_range(0, 7);
         if (r == 0) cpu_addr = 32'd4096;
         else if (r == 1) cpu_addr = 32'd4097;
         else if (r == 2) cpu_addr = $urandom;
         else cpu_addr = 32'($urandom_range(0, 63));
         cpu_data = $urandom;
         sw_in    = 16'($urandom);
         if (!(dma_req && !last_gnt && $urandom_range(0, 49) != 0)) begin
            dma_req  = ($urandom_range(0, 1) == 1);
            dma_addr = 12'($urandom_range(0, 63));
         end
         sample();
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
